// File: rtl/dma_pkg.sv
// Shared definitions for the DMA read and write masters.
package dma_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } dma_state_t;

   localparam logic [31:0] BYTES_PER_WORD      = 32'd4;
   localparam int unsigned DEFAULT_FIFO_DEPTH  = 64;
   localparam int unsigned DEFAULT_MAX_PENDING = 8;

   // Force a byte address onto a 32-bit word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/dma_read_master_if.sv
// Avalon-MM pipelined read port of the DMA read master.
interface dma_read_master_if;

   logic        oRM_read;
   logic [31:0] oRM_readaddress;
   logic        iRM_waitrequest;
   logic [31:0] iRM_readdata;
   logic        iRM_readdatavalid;

   modport master (
      output oRM_read,
      output oRM_readaddress,
      input  iRM_waitrequest,
      input  iRM_readdata,
      input  iRM_readdatavalid
   );

   modport slave (
      input  oRM_read,
      input  oRM_readaddress,
      output iRM_waitrequest,
      output iRM_readdata,
      output iRM_readdatavalid
   );

endinterface

// File: rtl/dma_read_master.sv
// DMA read master: issues pipelined Avalon-MM word reads and streams the
// returned data into a downstream FIFO, throttled so that words in flight
// never exceed MAX_PENDING or the FIFO's free space.
module dma_read_master
   import dma_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
   parameter int unsigned USEDW_W     = 7,
   parameter int unsigned MAX_PENDING = DEFAULT_MAX_PENDING
) (
   input  logic               iClk,
   input  logic               iReset_n,
   input  logic               Start,
   input  logic [31:0]        Length,
   input  logic [31:0]        RM_startaddress,
   dma_read_master_if.master  rm,
   output logic               FF_write,
   output logic [31:0]        FF_data,
   input  logic               FF_full,
   input  logic [USEDW_W-1:0] FF_usedw,
   output logic               RM_busy,
   output logic               RM_done,
   output logic               RM_overflow
);

   localparam int unsigned CW = $clog2(MAX_PENDING + 1);

   dma_state_t    state;
   logic [29:0]   words_left;
   logic [31:0]   addr_q;
   logic          read_q;
   logic [CW-1:0] credit;
   logic          consume_q;

   logic          accept;
   logic          consume;
   logic [CW-1:0] credit_nxt;
   logic          room;
   logic          unused_len_bits;

   // Sub-word length bits never produce a read.
   assign unused_len_bits = &{1'b0, Length[1:0]};

   assign rm.oRM_read        = read_q;
   assign rm.oRM_readaddress = addr_q;

   // Credit is decremented on the cycle the word leaves the write register
   // (consume_q), so a word stays counted until the FIFO has taken it; the
   // availability test subtracts that pending decrement to avoid claiming
   // the same credit twice on back-to-back returns.
   always_comb begin
      accept     = read_q && !rm.iRM_waitrequest;
      consume    = rm.iRM_readdatavalid && (credit > CW'(consume_q));
      credit_nxt = credit + CW'(accept) - CW'(consume_q);
      room       = (credit_nxt < CW'(MAX_PENDING)) &&
                   ((32'(FF_usedw) + 32'(credit_nxt)) < 32'(FIFO_DEPTH));
   end

   // Control FSM: command latch, read issue and completion handshake.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         state       <= S_IDLE;
         words_left  <= '0;
         addr_q      <= '0;
         read_q      <= 1'b0;
         RM_busy     <= 1'b0;
         RM_done     <= 1'b0;
         RM_overflow <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  words_left  <= Length[31:2];
                  addr_q      <= word_align(RM_startaddress);
                  RM_overflow <= 1'b0;
                  RM_busy     <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (accept) begin
                  addr_q     <= addr_q + BYTES_PER_WORD;
                  words_left <= words_left - 30'd1;
                  read_q     <= (words_left != 30'd1) && room;
               end else if (!read_q) begin
                  if (words_left == '0) begin
                     state <= S_DRAIN;
                  end else begin
                     read_q <= room;
                  end
               end
            end
            S_DRAIN: begin
               if (credit == '0) begin
                  RM_done <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               RM_done <= 1'b0;
               RM_busy <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (consume && FF_full) begin
            RM_overflow <= 1'b1;
         end
      end
   end

   // Return path: one-cycle registered FIFO write and in-flight credit.
   always_ff @(posedge iClk or negedge iReset_n) begin
      if (!iReset_n) begin
         credit    <= '0;
         consume_q <= 1'b0;
         FF_write  <= 1'b0;
         FF_data   <= '0;
      end else begin
         credit    <= credit_nxt;
         consume_q <= consume;
         FF_write  <= consume && !FF_full;
         if (consume && !FF_full) begin
            FF_data <= rm.iRM_readdata;
         end
      end
   end

endmodule

// File: doc/dma_read_master.md
DMA_READ_MASTER -- requirements
Module: dma_read_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 64: word capacity of the downstream FIFO.
REQ-002 Parameter USEDW_W, default 7: width of FF_usedw; it can represent 0..FIFO_DEPTH.
REQ-003 Parameter MAX_PENDING, default 8: maximum number of words accepted on the bus but not yet written to the FIFO.
REQ-004 iClk  in  1  clock; all logic on the rising edge.
REQ-005 iReset_n  in  1  reset, asynchronous, active-low.
REQ-006 Start  in  1  one-cycle start pulse; sampled only in IDLE.
REQ-007 Length  in  32  transfer size in bytes; sampled with Start.
REQ-008 RM_startaddress  in  32  source byte address; sampled with Start.
REQ-009 oRM_read  out  1  Avalon-MM read request.
REQ-010 oRM_readaddress  out  32  Avalon-MM read address, word aligned.
REQ-011 iRM_waitrequest  in  1  slave stall.
REQ-012 iRM_readdata  in  32  returned read data.
REQ-013 iRM_readdatavalid  in  1  iRM_readdata is valid this cycle (pipelined reads).
REQ-014 FF_write  out  1  FIFO write strobe.
REQ-015 FF_data  out  32  FIFO write data.
REQ-016 FF_full  in  1  FIFO full.
REQ-017 FF_usedw  in  USEDW_W  FIFO fill level in words.
REQ-018 RM_busy  out  1  high from Start acceptance until the cycle RM_done is pulsed (inclusive).
REQ-019 RM_done  out  1  one-cycle completion pulse.
REQ-020 RM_overflow  out  1  sticky error flag; cleared only by reset or by an accepted Start.

Function
REQ-021 Start pulse in IDLE: latch words_left = Length[31:2], latch address = {RM_startaddress[31:2], 2'b00}, clear RM_overflow, assert RM_busy, enter ISSUE.
REQ-022 Length[1:0] is ignored, so a partial trailing word is never read.
REQ-023 Start while RM_busy is ignored.
REQ-024 States: IDLE, ISSUE, DRAIN, DONE.
REQ-025 Transitions: IDLE->ISSUE on Start; ISSUE->DRAIN when words_left reaches 0; DRAIN->DONE when credit == 0; DONE->IDLE after one cycle.
REQ-026 Length < 4: ISSUE->DRAIN->DONE with no bus reads; RM_done is high 3 cycles after Start.
REQ-027 credit = words accepted on the bus minus words written to the FIFO; width clog2(MAX_PENDING+1).
REQ-028 In ISSUE, oRM_read rises only when words_left > 0, credit < MAX_PENDING and FF_usedw + credit < FIFO_DEPTH.
REQ-029 Once high, oRM_read and oRM_readaddress stay stable until the cycle where oRM_read && !iRM_waitrequest (acceptance).
REQ-030 On acceptance: address += 4, words_left -= 1, credit += 1; oRM_read may stay high for back-to-back reads if the REQ-028 condition still holds.
REQ-031 The address counter wraps modulo 2^32 with no error.
REQ-032 iRM_readdatavalid with credit > 0: FF_data <= iRM_readdata and FF_write <= 1 on the next edge; latency exactly 1 cycle; credit -= 1 on that FF_write.
REQ-033 Acceptance and FF_write in the same cycle leave credit unchanged.
REQ-034 iRM_readdatavalid with credit == 0 is ignored; no FF_write occurs.
REQ-035 iRM_readdatavalid while FF_full: data is dropped, no FF_write occurs, RM_overflow is set, and credit still decrements.
REQ-036 RM_done pulses high for exactly the one cycle spent in DONE; RM_busy falls the following cycle.

Reset
REQ-037 iReset_n low forces asynchronously: state=IDLE; oRM_read=0, oRM_readaddress=0, FF_write=0, FF_data=0, RM_busy=0, RM_done=0, RM_overflow=0, credit=0, words_left=0.
REQ-038 Reset mid-transfer abandons the transfer; read data returned after reset release is ignored per REQ-034.

Structure
REQ-039 Shared package dma_pkg holds the state enumeration, BYTES_PER_WORD=4 and the default FIFO_DEPTH/MAX_PENDING constants; the write-side master uses the same package.
REQ-040 The block is a single module with no sub-modules; the credit and word counters are inline.

Verification
REQ-041 Start, Length=16, addr=0x1000, no waitrequest, readdatavalid 2 cycles after accept -> reads at 0x1000, 0x1004, 0x1008, 0x100C; 4 FF_writes in order; one RM_done; RM_overflow=0.
REQ-042 Length=8 with waitrequest held high 5 cycles on the first read -> address 0x1000 stable throughout the stall; exactly 2 accepts.
REQ-043 FF_usedw=62, FIFO_DEPTH=64, Length=64 -> at most 2 reads outstanding until FF_usedw falls; no overflow.
REQ-044 Length=3 -> no oRM_read; RM_done 3 cycles after Start.
REQ-045 Reset asserted after 2 of 8 words accepted -> all outputs at reset values immediately; next Start runs cleanly.
REQ-046 Force FF_full while readdatavalid arrives -> no FF_write; RM_overflow=1 until the next Start.
